// File: rtl/rcb_frl_pkg.sv
// rcb_frl_pkg: shared types and constants for the FRL receive-side bit alignment slice.
package rcb_frl_pkg;
   localparam int TAP_W_DEF = 7;
   localparam logic [31:0] TRAIN_PATTERN = 32'hF0E1_D2C3;
   typedef enum logic [3:0] {
      S_IDLE, S_RST_TAP, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP_UP, S_CENTER, S_DONE, S_FAIL
   } state_t;
   typedef enum logic {PH_SEEK, PH_TRACK} phase_t;
endpackage

// File: rtl/rcb_frl_tap_tracker.sv
// rcb_frl_tap_tracker: saturating 0..MAX_TAP shadow of the delay-line tap counter.
module rcb_frl_tap_tracker import rcb_frl_pkg::*; #(
   parameter int TAP_W   = TAP_W_DEF,
   parameter int MAX_TAP = 127
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_ce,
   input  logic             i_inc,
   output logic [TAP_W-1:0] o_tap_value
);
   always_ff @(posedge clk or posedge rst)
      if (rst) o_tap_value <= '0;
      else if (i_clr) o_tap_value <= '0;
      else if (i_ce && i_inc && o_tap_value != TAP_W'(MAX_TAP)) o_tap_value <= o_tap_value + 1'b1;
      else if (i_ce && !i_inc && o_tap_value != '0) o_tap_value <= o_tap_value - 1'b1;
endmodule

// File: rtl/rcb_frl_tap_align_ctrl.sv
// rcb_frl_tap_align_ctrl: sweeps delay taps, finds the first data eye and parks the tap at its centre.
module rcb_frl_tap_align_ctrl import rcb_frl_pkg::*; #(
   parameter int TAP_W      = TAP_W_DEF,
   parameter int MAX_TAP    = 127,
   parameter int SETTLE_CYC = 8,
   parameter int SAMPLES    = 16,
   parameter int MIN_EYE    = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_sample_valid,
   input  logic             i_pattern_match,
   output logic             o_dly_rst,
   output logic             o_dly_ce,
   output logic             o_dly_inc,
   output logic [TAP_W-1:0] o_tap_value,
   output logic [TAP_W-1:0] o_eye_left,
   output logic [TAP_W-1:0] o_eye_right,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_fail
);
   localparam int CW = $clog2((SETTLE_CYC > SAMPLES ? SETTLE_CYC : SAMPLES) + 1);
   state_t           r_state;
   phase_t           r_phase;
   logic [CW-1:0]    r_cnt;
   logic             r_bad, r_dly_rst, r_dly_ce, r_dly_inc, r_busy, r_done, r_fail;
   logic [TAP_W-1:0] r_eye_left, r_eye_right, w_tap, w_span, w_centre;
   logic             w_at_max;
   assign w_span   = r_eye_right - r_eye_left;
   assign w_centre = r_eye_left + (w_span >> 1);
   assign w_at_max = w_tap == TAP_W'(MAX_TAP);
   rcb_frl_tap_tracker #(.TAP_W(TAP_W), .MAX_TAP(MAX_TAP)) u_trk (
      .clk(clk), .rst(rst), .i_clr(r_dly_rst), .i_ce(r_dly_ce), .i_inc(r_dly_inc), .o_tap_value(w_tap)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_phase     <= PH_SEEK;
         r_cnt       <= '0;
         r_bad       <= 1'b0;
         r_dly_rst   <= 1'b0;
         r_dly_ce    <= 1'b0;
         r_dly_inc   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
         r_eye_left  <= '0;
         r_eye_right <= '0;
      end else begin
         r_dly_rst <= 1'b0;
         r_dly_ce  <= 1'b0;
         r_dly_inc <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_FAIL:
               if (i_start) begin
                  r_state     <= S_RST_TAP;
                  r_done      <= 1'b0;
                  r_fail      <= 1'b0;
                  r_eye_left  <= '0;
                  r_eye_right <= '0;
                  r_busy      <= 1'b1;
                  r_dly_rst   <= 1'b1;
               end
            S_RST_TAP: begin
               r_state <= S_SETTLE;
               r_cnt   <= '0;
               r_phase <= PH_SEEK;
            end
            S_SETTLE: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(SETTLE_CYC - 1)) begin
                  r_state <= S_SAMPLE;
                  r_cnt   <= '0;
                  r_bad   <= 1'b0;
               end
            end
            S_SAMPLE:
               if (i_sample_valid) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (!i_pattern_match) r_bad <= 1'b1;
                  if (r_cnt == CW'(SAMPLES - 1)) r_state <= S_EVAL;
               end
            S_EVAL: begin
               if (!r_bad) begin
                  r_eye_right <= w_tap;
                  if (r_phase == PH_SEEK) r_eye_left <= w_tap;
                  r_phase <= PH_TRACK;
               end
               // a good tap at the top of the range closes the eye there
               if (r_bad && r_phase == PH_TRACK) r_state <= S_CENTER;
               else if (!w_at_max) begin
                  r_state   <= S_STEP_UP;
                  r_dly_ce  <= 1'b1;
                  r_dly_inc <= 1'b1;
               end else if (!r_bad || r_phase == PH_TRACK) r_state <= S_CENTER;
               else begin
                  r_state <= S_FAIL;
                  r_fail  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_STEP_UP: begin
               r_state <= S_SETTLE;
               r_cnt   <= '0;
            end
            S_CENTER:
               if (w_span < TAP_W'(MIN_EYE - 1)) begin
                  r_state <= S_FAIL;
                  r_fail  <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (!r_dly_ce && w_tap > w_centre) r_dly_ce <= 1'b1;
               else if (!r_dly_ce) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign o_dly_rst   = r_dly_rst;
   assign o_dly_ce    = r_dly_ce;
   assign o_dly_inc   = r_dly_inc;
   assign o_tap_value = w_tap;
   assign o_eye_left  = r_eye_left;
   assign o_eye_right = r_eye_right;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_fail      = r_fail;
endmodule

// File: tb/tb_rcb_frl_tap_align_ctrl.sv
// tb_rcb_frl_tap_align_ctrl: scoreboard bench with a delay-line/pattern-checker model and eye reference.
module tb_rcb_frl_tap_align_ctrl;
   localparam int TAP_W = 7, MAX_TAP = 127, SETTLE_CYC = 8, SAMPLES = 16, MIN_EYE = 4, LIMIT = 20000;
   typedef struct {
      int done; int fail; int left; int right; int tap; int incs; int decs;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_sample_valid = 1'b0, i_pattern_match = 1'b0;
   logic o_dly_rst, o_dly_ce, o_dly_inc, o_busy, o_done, o_fail;
   logic [TAP_W-1:0] o_tap_value, o_eye_left, o_eye_right;
   int compared = 0, mismatched = 0;
   int inc_n = 0, dec_n = 0, rst_n = 0;
   int inj_tap = -1, inj_n = 0;
   bit sparse = 1'b0;
   bit good [MAX_TAP+1];
   exp_t q[$];

   always #5 clk = ~clk;

   rcb_frl_tap_align_ctrl #(.TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .SETTLE_CYC(SETTLE_CYC),
                            .SAMPLES(SAMPLES), .MIN_EYE(MIN_EYE)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_sample_valid(i_sample_valid),
      .i_pattern_match(i_pattern_match), .o_dly_rst(o_dly_rst), .o_dly_ce(o_dly_ce),
      .o_dly_inc(o_dly_inc), .o_tap_value(o_tap_value), .o_eye_left(o_eye_left),
      .o_eye_right(o_eye_right), .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail)
   );

   task automatic check(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // First contiguous good region wins; the sweep stops one tap past it (or at the top).
   function automatic exp_t model();
      exp_t e;
      int l, r, last;
      bit g;
      e = '{default: 0};
      l = -1;
      r = -1;
      for (int t = 0; t <= MAX_TAP; t++) begin
         g = good[t] && t != inj_tap;
         if (l < 0 && g) begin l = t; r = t; end
         else if (l >= 0 && r == t - 1 && g) r = t;
      end
      if (l < 0) begin
         e.fail = 1; e.tap = MAX_TAP; e.incs = MAX_TAP;
         return e;
      end
      e.left = l; e.right = r;
      last = (r == MAX_TAP) ? MAX_TAP : r + 1;
      e.incs = last;
      if (r - l + 1 < MIN_EYE) begin
         e.fail = 1; e.tap = last;
      end else begin
         e.done = 1; e.tap = l + (r - l) / 2; e.decs = last - e.tap;
      end
      return e;
   endfunction

   // Delay line + pattern checker stand-in, driven off the DUT's strobes.
   initial begin
      int tb_tap, age, n_valid, inj_idx, nt;
      bit pdr, pce, pinc, m;
      tb_tap = 0; age = 0; n_valid = 0; inj_idx = 0;
      forever begin
         @(negedge clk);
         if (i_sample_valid) n_valid++;
         nt = pdr ? 0 : !pce ? tb_tap : pinc ? (tb_tap < MAX_TAP ? tb_tap + 1 : tb_tap)
                                             : (tb_tap > 0 ? tb_tap - 1 : 0);
         if (rst) nt = 0;
         if (nt != tb_tap) begin tb_tap = nt; age = 0; n_valid = 0; inj_idx = 0; end
         else age++;
         if (!rst && o_dly_ce && o_dly_inc) check("samples_before_step", int'(n_valid >= SAMPLES), 1);
         pdr = o_dly_rst; pce = o_dly_ce; pinc = o_dly_inc;
         if (rst) begin pdr = 0; pce = 0; end
         i_sample_valid = sparse ? ($urandom_range(0, 3) == 0) : 1'b1;
         m = good[tb_tap];
         if (i_sample_valid && tb_tap == inj_tap && age > SETTLE_CYC) begin
            if (inj_idx == inj_n) m = 1'b0;
            inj_idx++;
         end
         i_pattern_match = i_sample_valid ? m : 1'($urandom);
      end
   end

   // Monitor: strobe invariants plus scoreboard pop on each completion.
   initial begin
      bit pce, pdone, pfail;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            inc_n = 0; dec_n = 0; rst_n = 0; pce = 0; pdone = 0; pfail = 0;
         end else begin
            if (o_dly_ce) begin
               check("ce_back_to_back", int'(pce), 0);
               check("ce_with_dly_rst", int'(o_dly_rst), 0);
               if (o_dly_inc) inc_n++; else dec_n++;
            end else if (o_dly_inc) check("inc_without_ce", int'(o_dly_inc), 0);
            if (o_dly_rst) rst_n++;
            if ((o_done && !pdone) || (o_fail && !pfail)) begin
               check("scoreboard_pending", int'(q.size() > 0), 1);
               if (q.size() > 0) begin
                  e = q.pop_front();
                  check("done", int'(o_done), e.done);
                  check("fail", int'(o_fail), e.fail);
                  check("busy", int'(o_busy), 0);
                  check("eye_left", int'(o_eye_left), e.left);
                  check("eye_right", int'(o_eye_right), e.right);
                  check("tap_value", int'(o_tap_value), e.tap);
                  check("inc_pulses", inc_n, e.incs);
                  check("dec_pulses", dec_n, e.decs);
                  check("dly_rst_pulses", rst_n, 1);
               end
               inc_n = 0; dec_n = 0; rst_n = 0;
            end
            pce = o_dly_ce; pdone = o_done; pfail = o_fail;
         end
      end
   end

   task automatic set_eye(input int l, input int r, input int l2, input int r2);
      for (int t = 0; t <= MAX_TAP; t++)
         good[t] = (l >= 0 && t >= l && t <= r) || (l2 >= 0 && t >= l2 && t <= r2);
   endtask

   task automatic pulse_start();
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (!(o_done || o_fail) && n < LIMIT) begin @(negedge clk); n++; end
      check("completion_in_time", int'(n < LIMIT), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic run(input int l, input int r, input int l2, input int r2, input bit sp, input int inj);
      set_eye(l, r, l2, r2);
      sparse = sp; inj_tap = inj; inj_n = $urandom_range(0, SAMPLES - 3);
      q.push_back(model());
      pulse_start();
      wait_end();
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, int'({o_dly_rst, o_dly_ce, o_dly_inc, o_tap_value, o_eye_left, o_eye_right,
                        o_busy, o_done, o_fail}), 0);
   endtask

   initial begin
      int n, l, r;
      bit seen;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_outputs");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run(40, 71, -1, -1, 1'b0, -1);
      run(0, 9, -1, -1, 1'b0, -1);
      run(100, 127, -1, -1, 1'b0, -1);
      run(-1, -1, -1, -1, 1'b0, -1);
      run(50, 52, -1, -1, 1'b0, -1);
      run(40, 71, -1, -1, 1'b1, 45);
      // abort a calibration while it is walking back towards the centre
      set_eye(40, 71, -1, -1); sparse = 1'b0; inj_tap = -1;
      q.push_back(model());
      pulse_start();
      n = 0;
      while (dec_n == 0 && n < LIMIT) begin @(negedge clk); n++; end
      check("reached_center", int'(n < LIMIT), 1);
      rst = 1'b1;
      q.delete();
      repeat (3) begin @(negedge clk); check_outputs_zero("outputs_in_reset"); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      set_eye(20, 35, -1, -1);
      q.push_back(model());
      pulse_start();
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (o_dly_rst) seen = 1'b1;
         @(negedge clk);
      end
      check("dly_rst_after_start", int'(seen), 1);
      repeat (50) @(negedge clk);
      check("busy_before_restart", int'(o_busy), 1);
      pulse_start();
      wait_end();
      repeat (3) begin
         l = $urandom_range(0, 110);
         r = $urandom_range(l, MAX_TAP);
         if (r + 3 <= MAX_TAP) run(l, r, r + 3, (r + 10 > MAX_TAP) ? MAX_TAP : r + 10, 1'($urandom_range(0, 1)), -1);
         else run(l, r, -1, -1, 1'($urandom_range(0, 1)), -1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/rcb_frl_tap_align_ctrl.md
Name: rcb_frl_tap_align_ctrl

Overview:
Receive-side bit-alignment controller for the Fast Radio Link. It drives the increment/decrement command pair (ce/inc) for the input delay line and its up/down tap counter, sweeping taps 0..MAX_TAP against the training pattern. It locates the first data eye, moves the tap to the eye centre, and reports done or fail. It sits between the per-lane pattern checker and the delay primitive/tap counter.

Parameters:
TAP_W, 7, tap position width
MAX_TAP, 127, highest legal tap
SETTLE_CYC, 8, idle cycles after each tap move before sampling (>=1)
SAMPLES, 16, valid samples evaluated per tap (>=1)
MIN_EYE, 4, minimum eye width in taps for success

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to (re)calibrate
sample_valid  in  1  pattern checker output valid
pattern_match  in  1  sampled word equals training pattern (qualified by sample_valid)
dly_rst  out  1  one-cycle pulse: delay line and tap counter to 0
dly_ce  out  1  one-cycle tap move strobe
dly_inc  out  1  direction with dly_ce: 1 = +1, 0 = -1
tap_value  out  TAP_W  shadow of current tap position
eye_left  out  TAP_W  first good tap
eye_right  out  TAP_W  last good tap
busy  out  1  calibration in progress
done  out  1  level, success
fail  out  1  level, failure

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters cleared. Reset mid-calibration aborts immediately; no further strobes are issued.
- States: IDLE, RST_TAP, SETTLE, SAMPLE, EVAL, STEP_UP, CENTER, DONE, FAIL.
- IDLE/DONE/FAIL + start -> RST_TAP. Entering RST_TAP clears done, fail, eye_left, eye_right, sets busy. start while busy is ignored.
- RST_TAP: dly_rst=1 for exactly one cycle. tap_value=0 next cycle. -> SETTLE.
- SETTLE: wait SETTLE_CYC cycles, then clear the sample counter and the bad flag. -> SAMPLE.
- SAMPLE: count cycles with sample_valid=1. sample_valid=0 stalls without timeout. Any valid sample with pattern_match=0 sets bad. After SAMPLES valid samples -> EVAL.
- EVAL, phase SEEK (no good tap seen yet):
  - good tap: eye_left=eye_right=tap, phase TRACK.
  - bad tap: step up.
- EVAL, phase TRACK:
  - good tap: eye_right=tap, step up.
  - bad tap: eye closed -> CENTER.
- Step up when tap==MAX_TAP:
  - in TRACK: eye closes with eye_right=MAX_TAP -> CENTER.
  - in SEEK: -> FAIL.
- STEP_UP: dly_ce=1, dly_inc=1 for one cycle. tap_value+1 on the next edge. -> SETTLE.
- Only the first eye is used; later good regions are ignored.
- CENTER:
  - width = eye_right-eye_left+1. width<MIN_EYE -> FAIL with tap left in place.
  - Otherwise centre = eye_left + ((eye_right-eye_left)>>1), floor, TAP_W-bit math, no overflow.
  - Issue dly_ce=1/dly_inc=0 pulses separated by at least one idle cycle until tap_value==centre.
  - Each pulse decrements tap_value on the next edge. -> DONE.
- DONE: done=1, busy=0. FAIL: fail=1, busy=0. Both hold until next start or reset. eye_left/eye_right hold their last values.
- Invariants:
  - dly_ce never asserted in consecutive cycles.
  - dly_ce and dly_rst never asserted together.
  - tap_value never leaves 0..MAX_TAP.
  - dly_inc is don't-care when dly_ce=0 but driven 0.

Decomposition:
- Shared package rcb_frl_pkg holds:
  - state enum
  - TAP_W default
  - training pattern constant used by the checker.
- One sub-module, rcb_frl_tap_tracker: saturating 0..MAX_TAP up/down register with sync clear. Inputs clr, ce, inc. Output tap_value. Instantiated to produce tap_value.

Test Plan:
- Eye at taps 40..71, sample_valid always 1, defaults -> 72 inc pulses, then 17 dec pulses. eye_left=40, eye_right=71, tap_value=55, done=1, fail=0.
- Eye at 0..9 -> eye_left=0, eye_right=9, 6 dec pulses from 10, tap_value=4, done=1.
- Eye at 100..127 -> no bad tap, eye_right=127, tap_value=113, done=1. tap_value never exceeds 127.
- Never matching -> 127 inc pulses, fail=1, tap_value=127, done=0. Narrow eye 50..52 -> fail=1, tap_value=53.
- sample_valid toggling 1-in-4 with one mismatch injected at tap 45 inside eye 40..71 -> eye_right=44, tap_value=42. Check no dly_ce during stalls and no back-to-back strobes.
- rst asserted mid-CENTER, then start, eye 20..35 -> all outputs 0 during reset, dly_rst pulse after start, final tap_value=27, done=1. start while busy has no effect.
